// File: rtl/sseg_reader_if.sv
// Seven-segment display bus as seen by the loop-back reader: the raw anode and
// cathode lines plus the decoded results the reader hands back.
interface sseg_reader_if #(
  parameter int CNT_W = 8
);
  logic [7:0]       SSEG_AN;
  logic [7:0]       SSEG_CA;
  logic [3:0]       VALUE;
  logic             VALID;
  logic             ERR;
  logic             DIGIT_ON;
  logic             DP;
  logic [CNT_W-1:0] CHG_CNT;

  modport master (
    output SSEG_AN, SSEG_CA,
    input  VALUE, VALID, ERR, DIGIT_ON, DP, CHG_CNT
  );

  modport slave (
    input  SSEG_AN, SSEG_CA,
    output VALUE, VALID, ERR, DIGIT_ON, DP, CHG_CNT
  );
endinterface

// File: rtl/sseg_reader.sv
// Seven-segment bus reader: synchronizes the active-low anode/cathode lines,
// debounces the digit pattern and decodes it back to a hex value with strobes.
module sseg_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic          CLK,
  input  logic          RST,
  sseg_reader_if.slave  bus
);

  localparam int SC_W = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [6:0] BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

  // Returns {legal, value}; legal is 0 for blank and any non-table pattern.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    case (seg)
      7'b1000000: return {1'b1, 4'h0};
      7'b1111001: return {1'b1, 4'h1};
      7'b0100100: return {1'b1, 4'h2};
      7'b0110000: return {1'b1, 4'h3};
      7'b0011001: return {1'b1, 4'h4};
      7'b0010010: return {1'b1, 4'h5};
      7'b0000010: return {1'b1, 4'h6};
      7'b1111000: return {1'b1, 4'h7};
      7'b0000000: return {1'b1, 4'h8};
      7'b0011000: return {1'b1, 4'h9};
      7'b0001000: return {1'b1, 4'hA};
      7'b0000011: return {1'b1, 4'hB};
      7'b1000110: return {1'b1, 4'hC};
      7'b0100001: return {1'b1, 4'hD};
      7'b0000110: return {1'b1, 4'hE};
      7'b0001110: return {1'b1, 4'hF};
      default:    return 5'b0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [7:0]       an_p0, an_p1, ca_p0, ca_p1;
  state_t           state, state_nxt;
  logic [SC_W-1:0]  cnt, cnt_nxt;
  logic [6:0]       cand, cand_nxt;
  logic [6:0]       last, last_nxt;
  logic             accept;
  logic             qual;
  logic [6:0]       pat;
  logic [4:0]       dec;
  logic [3:0]       value_p2, value_nxt;
  logic             valid_p2, valid_nxt;
  logic             err_p2, err_nxt;
  logic             digit_on_p2, dp_p2;
  logic [CNT_W-1:0] chg_p2, chg_nxt;

  assign qual = (an_p1 == 8'hFE);
  assign pat  = ca_p1[6:0];

  // Stage p0/p1: two-flop synchronizer, idles at all-off
  always_ff @(posedge CLK) begin
    if (RST) begin
      an_p0 <= 8'hFF;
      an_p1 <= 8'hFF;
      ca_p0 <= 8'hFF;
      ca_p1 <= 8'hFF;
    end else begin
      an_p0 <= bus.SSEG_AN;
      an_p1 <= an_p0;
      ca_p0 <= bus.SSEG_CA;
      ca_p1 <= ca_p0;
    end
  end

  // Stage p2: FSM state and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      last        <= BLANK;
      value_p2    <= 4'h0;
      valid_p2    <= 1'b0;
      err_p2      <= 1'b0;
      digit_on_p2 <= 1'b0;
      dp_p2       <= 1'b0;
      chg_p2      <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      last        <= last_nxt;
      value_p2    <= value_nxt;
      valid_p2    <= valid_nxt;
      err_p2      <= err_nxt;
      digit_on_p2 <= qual;
      dp_p2       <= ~ca_p1[7];
      chg_p2      <= chg_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    cand <= cand_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cand_nxt  = cand;
    accept    = 1'b0;
    if (!qual) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = TRACK;
          cnt_nxt   = SC_W'(1);
          cand_nxt  = pat;
        end
        TRACK: begin
          if (pat != cand) begin
            cnt_nxt  = SC_W'(1);
            cand_nxt = pat;
          end else begin
            cnt_nxt = cnt + SC_W'(1);
          end
        end
        HOLD: begin
          if (pat != cand) begin
            state_nxt = TRACK;
            cnt_nxt   = SC_W'(1);
            cand_nxt  = pat;
          end
        end
        default: state_nxt = IDLE;
      endcase
      // The count check covers entry into TRACK too, so a depth of 1 accepts at once
      if (state_nxt == TRACK && cnt_nxt == SC_W'(STABLE_CYCLES)) begin
        state_nxt = HOLD;
        accept    = (cand_nxt != last);
      end
    end
  end

  always_comb begin
    dec       = decode_seg(cand_nxt);
    valid_nxt = accept && dec[4];
    err_nxt   = accept && !dec[4] && (cand_nxt != BLANK);
    value_nxt = valid_nxt ? dec[3:0] : value_p2;
    chg_nxt   = valid_nxt ? sat_inc(chg_p2) : chg_p2;
    last_nxt  = accept ? cand_nxt : last;
  end

  assign bus.VALUE    = value_p2;
  assign bus.VALID    = valid_p2;
  assign bus.ERR      = err_p2;
  assign bus.DIGIT_ON = digit_on_p2;
  assign bus.DP       = dp_p2;
  assign bus.CHG_CNT  = chg_p2;

endmodule

// File: tb/tb_sseg_reader.sv
// Bench for sseg_reader: directed scenarios plus random bus traffic, checked
// every cycle against a run-length reference model of the display path.
module tb_sseg_reader;

  localparam int S = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sseg_reader_if #(.CNT_W(8)) bus ();
  sseg_reader_if #(.CNT_W(2)) sbus ();

  sseg_reader #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
    .CLK(clk), .RST(rst), .bus(bus)
  );
  sseg_reader #(.STABLE_CYCLES(S), .CNT_W(2)) dut_sat (
    .CLK(clk), .RST(rst), .bus(sbus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [6:0] tbl [16];

  // Reference model: inputs delayed two edges, then a run length of identical
  // qualifying samples; a new pattern is taken when the run reaches S.
  logic [7:0] m_s1_an, m_s1_ca, m_s2_an, m_s2_ca;
  int         run;
  logic [6:0] run_pat, last_acc;
  logic [3:0] e_value;
  logic       e_valid, e_err, e_don, e_dp;
  int         e_cnt;
  int         n_valid, n_err, n_svalid, first;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int seg_val(input logic [6:0] p);
    for (int i = 0; i < 16; i++)
      if (tbl[i] == p) return i;
    return -1;
  endfunction

  task automatic model_edge(input logic r, input logic [7:0] an, input logic [7:0] ca);
    logic [7:0] san, sca;
    int v;
    if (r) begin
      m_s1_an = 8'hFF; m_s1_ca = 8'hFF; m_s2_an = 8'hFF; m_s2_ca = 8'hFF;
      run = 0; run_pat = 7'h7F; last_acc = 7'h7F;
      e_value = 4'h0; e_valid = 1'b0; e_err = 1'b0; e_don = 1'b0; e_dp = 1'b0;
      e_cnt = 0;
    end else begin
      san = m_s2_an; sca = m_s2_ca;
      m_s2_an = m_s1_an; m_s2_ca = m_s1_ca;
      m_s1_an = an;      m_s1_ca = ca;
      e_don = (san == 8'hFE);
      e_dp  = ~sca[7];
      e_valid = 1'b0;
      e_err   = 1'b0;
      if (san != 8'hFE) run = 0;
      else if (run > 0 && sca[6:0] == run_pat) run++;
      else begin
        run = 1;
        run_pat = sca[6:0];
      end
      if (run == S && run_pat != last_acc) begin
        last_acc = run_pat;
        v = seg_val(run_pat);
        if (v >= 0) begin
          e_value = v[3:0];
          e_valid = 1'b1;
          e_cnt++;
        end else if (run_pat != 7'h7F) begin
          e_err = 1'b1;
        end
      end
    end
  endtask

  task automatic cyc(input logic [7:0] an, input logic [7:0] ca, input logic r);
    bus.SSEG_AN = an;  bus.SSEG_CA = ca;
    sbus.SSEG_AN = an; sbus.SSEG_CA = ca;
    rst = r;
    @(posedge clk);
    model_edge(r, an, ca);
    #1;
    chk("value",     bus.VALUE,    e_value);
    chk("valid",     bus.VALID,    e_valid);
    chk("err",       bus.ERR,      e_err);
    chk("digit_on",  bus.DIGIT_ON, e_don);
    chk("dp",        bus.DP,       e_dp);
    chk("chg_cnt",   bus.CHG_CNT,  (e_cnt > 255) ? 255 : e_cnt);
    chk("sat_cnt",   sbus.CHG_CNT, (e_cnt > 3) ? 3 : e_cnt);
    chk("sat_valid", sbus.VALID,   e_valid);
    chk("excl",      bus.VALID & bus.ERR, 0);
    n_valid  += bus.VALID;
    n_err    += bus.ERR;
    n_svalid += sbus.VALID;
  endtask

  task automatic hold(input logic [7:0] an, input logic [7:0] ca, input int n);
    for (int i = 0; i < n; i++) cyc(an, ca, 1'b0);
  endtask

  initial begin
    logic [7:0] an, ca;
    int r, len;
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    n_valid = 0; n_err = 0; n_svalid = 0;

    // Reset and first digit
    cyc(8'hFF, 8'hFF, 1'b1);
    cyc(8'hFF, 8'hFF, 1'b1);
    chk("rst_value", bus.VALUE, 0);
    chk("rst_cnt", bus.CHG_CNT, 0);
    chk("rst_don", bus.DIGIT_ON, 0);
    n_valid = 0; n_err = 0; first = -1;
    for (int i = 0; i < 10; i++) begin
      cyc(8'hFE, 8'h40, 1'b0);
      if (bus.VALID && first < 0) first = i;
    end
    chk("first_lat", first, S + 1);
    chk("first_nvalid", n_valid, 1);
    chk("first_cnt", bus.CHG_CNT, 1);
    chk("first_nerr", n_err, 0);
    chk("first_dp", bus.DP, 1);

    // Full table from a fresh reset
    cyc(8'hFF, 8'hFF, 1'b1);
    n_valid = 0;
    for (int d = 0; d < 16; d++) hold(8'hFE, {1'b1, tbl[d]}, 10);
    chk("table_nvalid", n_valid, 16);
    chk("table_cnt", bus.CHG_CNT, 16);
    chk("table_value", bus.VALUE, 15);

    // Glitch shorter than the filter depth
    hold(8'hFE, 8'h12, 10);
    n_valid = 0; n_err = 0;
    hold(8'hFE, 8'h79, S - 1);
    hold(8'hFE, 8'h12, 10);
    chk("glitch_nvalid", n_valid, 0);
    chk("glitch_nerr", n_err, 0);
    chk("glitch_value", bus.VALUE, 5);

    // Illegal pattern, then blank
    n_valid = 0; n_err = 0;
    hold(8'hFE, 8'h55, 20);
    chk("ill_nerr", n_err, 1);
    chk("ill_value", bus.VALUE, 5);
    chk("ill_cnt", bus.CHG_CNT, 17);
    hold(8'hFE, 8'h7F, 20);
    chk("blank_nerr", n_err, 1);
    chk("blank_nvalid", n_valid, 0);

    // Anode dropout during tracking of digit 2
    hold(8'hFE, 8'h24, 2);
    hold(8'hFF, 8'h24, 3);
    chk("drop_don", bus.DIGIT_ON, 0);
    chk("drop_nvalid", n_valid, 0);
    first = -1;
    for (int i = 0; i < 12; i++) begin
      cyc(8'hFE, 8'h24, 1'b0);
      if (bus.VALID && first < 0) first = i;
    end
    chk("requal_lat", first, S + 1);
    chk("requal_value", bus.VALUE, 2);

    // Reset on the very edge a VALID is due
    for (int i = 0; i <= S; i++) cyc(8'hFE, 8'h79, 1'b0);
    cyc(8'hFE, 8'h79, 1'b1);
    chk("rstv_valid", bus.VALID, 0);
    chk("rstv_value", bus.VALUE, 0);
    chk("rstv_cnt", bus.CHG_CNT, 0);
    chk("rstv_err", bus.ERR, 0);
    n_valid = 0;
    hold(8'hFE, 8'hC0, 10);
    chk("zero_nvalid", n_valid, 1);
    chk("zero_cnt", bus.CHG_CNT, 1);

    // Saturation of the 2-bit counter
    cyc(8'hFF, 8'hFF, 1'b1);
    n_svalid = 0;
    for (int k = 0; k < 7; k++) hold(8'hFE, {1'b1, tbl[(k % 2) + 1]}, 8);
    chk("sat_nvalid", n_svalid, 7);
    chk("sat_final", sbus.CHG_CNT, 3);

    // Random traffic
    for (int seg = 0; seg < 400; seg++) begin
      r = $urandom_range(0, 39);
      if (r == 0) begin
        cyc(8'hFF, 8'hFF, 1'b1);
      end else begin
        an = (r < 4) ? ((r == 1) ? 8'($urandom) : 8'hFF) : 8'hFE;
        r = $urandom_range(0, 9);
        if (r < 6)       ca = {1'($urandom), tbl[$urandom_range(0, 15)]};
        else if (r == 6) ca = {1'($urandom), 7'h7F};
        else             ca = 8'($urandom);
        len = $urandom_range(1, 2 * S + 2);
        hold(an, ca, len);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sseg_reader.md
# sseg_reader

Receive-side decoder for the single-digit seven-segment display bus. It samples the active-low anode and cathode lines driven by the counter and display logic, and filters out transient patterns. Each stable digit pattern is decoded back to its 4-bit value, with valid and error strobes. It sits on the bench or on a second board as the loop-back checker for the display path.

## Interface
- STABLE_CYCLES, 4, number of consecutive identical synchronized samples required before a pattern is accepted (legal range ≥1).
- CNT_W, 8, width of the accepted-change counter.
- CLK  in  1  system clock, all logic on posedge.
- RST  in  1  reset; synchronous and active-high.
- SSEG_AN  in  8  anode enables, active-low; only 8'b11111110 (digit 0 on) qualifies.
- SSEG_CA  in  8  cathodes, active-low; bit7 = DP, bits[6:0] = g,f,e,d,c,b,a.
- VALUE  out  4  last successfully decoded hex digit.
- VALID  out  1  one-cycle pulse when a new legal digit is accepted.
- ERR  out  1  one-cycle pulse when a stable non-table, non-blank pattern is accepted.
- DIGIT_ON  out  1  registered level, 1 while the synchronized anode qualifies.
- DP  out  1  registered level, 1 while the synchronized DP cathode is low (lit).
- CHG_CNT  out  CNT_W  count of VALID pulses; saturates at all-ones.

## Operation
- **Input synchronizer:** two flop stages on SSEG_AN and SSEG_CA. Reset value of both stages is 8'hFF, meaning all off.
- **Decode table** (bits[6:0] → VALUE):
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3
  - 0011001→4, 0010010→5, 0000010→6, 1111000→7
  - 0000000→8, 0011000→9, 0001000→A, 0000011→B
  - 1000110→C, 0100001→D, 0000110→E, 0001110→F
- **Blank pattern:** 1111111 (all segments off) is neither legal nor error.
- **DP:** excluded from the stability compare and from decode.
- **FSM states:**
  - IDLE: anode not qualifying. Stability count is 0.
  - TRACK: counting identical samples of a candidate pattern.
  - HOLD: candidate accepted; waiting for the pattern to change.
- **FSM transitions:**
  - Any state → IDLE when the synchronized anode does not qualify. The last-accepted pattern is retained.
  - IDLE → TRACK when the anode qualifies. Count = 1 with the current sample as candidate.
  - TRACK, sample ≠ candidate → stay in TRACK. Candidate = sample, count = 1.
  - TRACK, sample = candidate and count reaches STABLE_CYCLES:
    - If candidate = last-accepted, go to HOLD with no strobe.
    - Otherwise accept and go to HOLD.
  - HOLD, sample ≠ candidate → TRACK, count = 1.
- **Accept action:**
  - Update last-accepted to the candidate.
  - Legal pattern: VALUE ← table entry, VALID = 1 for one cycle, CHG_CNT += 1 (saturating).
  - Blank pattern: no strobe, VALUE held.
  - Any other pattern: ERR = 1 for one cycle, VALUE held. ERR therefore fires once per distinct bad pattern.
- VALID and ERR are never asserted together.
- **Anode dropout mid-TRACK:** discards the partial count. Re-qualification restarts the count from 1.
- **Reset mid-operation:**
  - Within one cycle: VALUE = 0, VALID = 0, ERR = 0, DIGIT_ON = 0, DP = 0, CHG_CNT = 0.
  - State = IDLE, last-accepted = 1111111, synchronizer stages = 8'hFF.
  - The first legal digit after reset always produces VALID, including 0.

## Timing
- **Acceptance latency:** a new pattern, held constant from the posedge it is first sampled at edge E, produces VALID/ERR registered at edge E + 2 + STABLE_CYCLES − 1. That is STABLE_CYCLES + 1 edges after first sampling.
- **DIGIT_ON and DP:** follow the inputs with 2-edge latency and no filtering.
- **Glitch rejection:** a pattern held fewer than STABLE_CYCLES synchronized samples produces no strobe.
- **Strobe rate:** minimum spacing between strobes is STABLE_CYCLES cycles.
- **RST:** takes priority over every other event in the same cycle.

## Test plan
- **Reset and first digit:** RST 2 cycles, drive AN = 8'hFE, CA = 8'h40 steady. Response: VALUE = 0, a single VALID at 1 + STABLE_CYCLES edges after first sample, CHG_CNT = 1, no ERR.
- **Full table:** step CA through all 16 table patterns, each held 10 cycles. Response: VALUE follows 0..F, 16 VALID pulses, CHG_CNT = 16.
- **Glitch:** from a stable 5 (CA = 8'h12), insert 8'h79 for STABLE_CYCLES − 1 cycles, then return to 8'h12. Response: no VALID/ERR, VALUE stays 5.
- **Illegal pattern:** CA = 8'h55 held 20 cycles. Response: exactly one ERR, VALUE unchanged, CHG_CNT unchanged. Then CA = 8'h7F (blank) produces no strobe.
- **Anode dropout and reset:**
  - During TRACK of 8'h24, set AN = 8'hFF for 3 cycles, then back to 8'hFE. Response: DIGIT_ON drops; VALID for 2 arrives STABLE_CYCLES + 1 edges after re-qualification.
  - Assert RST in the same cycle a VALID is due. Response: no VALID, all outputs 0.
- **Saturation:** CNT_W = 2, seven alternating legal digits. Response: CHG_CNT sticks at 3 while VALID still pulses 7 times.
